line_buffer_taps: RTL and testbench
===================================

# line_buffer_taps

Parametrised multi-line buffer producing vertically aligned column taps for windowed image filters (erosion/dilation, 3x3 and larger kernels) in the motion-detection datapath. Accepts one pixel of DATA_W bits per `in_valid` cycle and presents the current pixel plus the same-column pixel from each of the previous NUM_LINES lines. Lines are stored in circular RAM (one per tap), not a shift chain, with one shared write pointer. The block tracks column and row fill so downstream logic knows when every tap holds real data.

## Interface
- DATA_W, 1: pixel width in bits.
- LINE_LEN, 640: pixels per line; must be ≥ 2.
- NUM_LINES, 2: number of stored lines (taps); must be ≥ 1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  frame-start clear (synchronous); resets pointer and counters only.
- in_valid  in  1  pixel strobe; the block never stalls.
- in_data  in  DATA_W  current pixel.
- out_valid  out  1  registered copy of `in_valid`.
- out_data  out  DATA_W  current pixel, delayed one cycle.
- taps  out  NUM_LINES*DATA_W  slice k (bits [k*DATA_W +: DATA_W]) = pixel k+1 lines above `out_data`, same column.
- out_col  out  $clog2(LINE_LEN)  column of `out_data`.
- tap_ready  out  NUM_LINES  bit k = slice k of `taps` holds data from the current frame.
- win_valid  out  1  `out_valid` AND all `tap_ready` bits set.

## Operation
- State: write pointer `ptr` (0..LINE_LEN-1), row-fill counter `rows` (0..NUM_LINES, saturating), memories mem[0..NUM_LINES-1], each LINE_LEN x DATA_W.
- On an accepted pixel (`in_valid`=1), all in one cycle at address `ptr`:
  - read-before-write on every memory.
  - taps[k] <= mem[k][ptr].
  - mem[0][ptr] <= in_data; mem[k][ptr] <= old mem[k-1][ptr] for k ≥ 1.
  - out_data <= in_data; out_col <= ptr.
- Pointer: increments on each accepted pixel. It wraps LINE_LEN-1 → 0, and `rows` increments on the wrap, saturating at NUM_LINES.
- tap_ready[k] is registered with the output as (rows > k), using `rows` before this pixel's update.
- `in_valid`=0: memories, `ptr` and `rows` hold. `out_valid` <= 0. out_data/taps/out_col/tap_ready hold their last values.
- clr=1: ptr <= 0 and rows <= 0. Memory contents are untouched (stale).
- clr=1 with in_valid=1 in the same cycle: the pixel is treated as column 0 of row 0 of the new frame.
  - It is written at address 0 and emitted with out_col=0, tap_ready=0.
  - Afterwards ptr=1, rows=0.
- rst: has the same effect on ptr and rows as `clr`. Additionally every output goes to 0. Memories are not cleared.
- Reset mid-line discards the partial line; the next accepted pixel is column 0.

## Timing
- Latency: one cycle from `in_valid` to `out_valid`/`out_data`/`taps`.
- Throughput: one pixel per clock, with arbitrary bubbles allowed.
- Reset values: out_valid=0, out_data=0, taps=0, out_col=0, tap_ready=0, win_valid=0.
- win_valid is combinational from registered `out_valid` and `tap_ready`; it adds no extra latency.
- Memories must map to inferred block RAM: one read and one write per memory per cycle, read-old-data on collision.

## Configuration
- LINE_BUFFER_ZERO_FILL_EN defined:
  - each taps slice k is forced to 0 whenever tap_ready[k]=0, including after rst or clr.
  - costs one AND-mask per slice on the output register input.
- LINE_BUFFER_ZERO_FILL_EN undefined:
  - taps carry whatever the memory holds (stale previous-frame data or power-up X) while not ready.
  - consumers must gate on tap_ready/win_valid.

## Test plan
Common setup: DATA_W=8, LINE_LEN=4, NUM_LINES=2.
- **Fill and window:** stream in_data 0..11 contiguously after rst.
  - Output for pixel 8: out_data=8, out_col=0, taps[0]=4, taps[1]=0, tap_ready=2'b11, win_valid=1.
  - Pixels 0..7: win_valid=0. Pixels 4..7: tap_ready=2'b01.
- **Bubbles:** same stream with in_valid toggled 1/0.
  - Identical out_data/taps sequence to the contiguous case.
  - out_valid=0 on gap cycles, with outputs held.
- **Mid-line clr:** clr after pixel 5; then stream 100..107.
  - Output for pixel 100: out_col=0, tap_ready=0.
  - Pixel 104: taps[0]=100, tap_ready=2'b01.
  - With LINE_BUFFER_ZERO_FILL_EN: taps[1]=0 at pixel 104.
- **clr with in_valid same cycle:** in_data=50.
  - out_col=0, tap_ready=0.
  - The next pixel has out_col=1.
- **Reset mid-operation:** assert rst during row 2.
  - Next cycle: all outputs 0.
  - The first pixel after reset has out_col=0, tap_ready=0.
- **Saturation and wrap:** stream 40 pixels.
  - `rows` stays at 2, and out_col cycles 0,1,2,3.
  - taps[1] = out_data-8 for every output from pixel 8 onward.

Source files
------------

// File: rtl/line_buffer_taps.sv
// line_buffer_taps: circular multi-line buffer that emits the current pixel
// plus the same-column pixel from each of the previous NUM_LINES lines.
// Optional feature macro: LINE_BUFFER_ZERO_FILL_EN (zero taps that are not ready).

// One stored line: asynchronous read, one write per cycle. The top module
// registers the read data, so a write and a read at the same address in one
// cycle return the old contents.
module line_buffer_line #(
  parameter int DATA_W   = 1,
  parameter int LINE_LEN = 640,
  parameter int AW       = $clog2(LINE_LEN)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [LINE_LEN];

  assign rd_data = mem[addr];

  // Line storage write port; contents are never reset.
  always_ff @(posedge clk)
    if (we) mem[addr] <= wr_data;
endmodule

module line_buffer_taps #(
  parameter int DATA_W    = 1,
  parameter int LINE_LEN  = 640,
  parameter int NUM_LINES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [NUM_LINES*DATA_W-1:0]   taps,
  output logic [$clog2(LINE_LEN)-1:0]   out_col,
  output logic [NUM_LINES-1:0]          tap_ready,
  output logic                          win_valid
);
  localparam int AW = $clog2(LINE_LEN);
  localparam int RW = $clog2(NUM_LINES + 1);

  logic [AW-1:0] ptr, cur_ptr;
  logic [RW-1:0] rows, cur_rows;
  logic          we;

  logic [NUM_LINES-1:0][DATA_W-1:0] rd, wr, taps_nxt, taps_q;
  logic [NUM_LINES-1:0]             rdy_nxt;

  // A clear in the same cycle as a pixel makes that pixel column 0 of row 0.
  assign cur_ptr  = clr ? '0 : ptr;
  assign cur_rows = clr ? '0 : rows;
  assign we       = in_valid & ~rst;

  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    // Line 0 takes the new pixel; each older line takes the displaced pixel
    // of the line below it, so the column shifts up one line per row.
    if (k == 0) begin : g_first
      assign wr[k] = in_data;
    end else begin : g_rest
      assign wr[k] = rd[k-1];
    end

    assign rdy_nxt[k] = 32'(cur_rows) > k;

`ifdef LINE_BUFFER_ZERO_FILL_EN
    assign taps_nxt[k] = rdy_nxt[k] ? rd[k] : '0;
`else
    assign taps_nxt[k] = rd[k];
`endif

    line_buffer_line #(.DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .AW(AW)) u_line (
      .clk     (clk),
      .we      (we),
      .addr    (cur_ptr),
      .wr_data (wr[k]),
      .rd_data (rd[k])
    );
  end

  assign taps      = taps_q;
  assign win_valid = out_valid & (&tap_ready);

  // Pointer/row-fill bookkeeping and the output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      rows      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_col   <= '0;
      taps_q    <= '0;
      tap_ready <= '0;
    end else begin
      out_valid <= in_valid;
      ptr       <= cur_ptr;
      rows      <= cur_rows;
      if (in_valid) begin
        out_data  <= in_data;
        out_col   <= cur_ptr;
        taps_q    <= taps_nxt;
        tap_ready <= rdy_nxt;
        if (cur_ptr == AW'(LINE_LEN - 1)) begin
          ptr <= '0;
          if (cur_rows != RW'(NUM_LINES)) rows <= cur_rows + 1'b1;
        end else begin
          ptr <= cur_ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_line_buffer_taps.sv
// Scoreboard bench for line_buffer_taps (DATA_W=8, LINE_LEN=4, NUM_LINES=2).
// The reference keeps every pixel of the current frame in arrival order and
// derives column, readiness and tap values from the pixel's frame index.
module tb_line_buffer_taps;
  localparam int DW = 8;
  localparam int L  = 4;
  localparam int N  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [N*DW-1:0]   taps;
  logic [$clog2(L)-1:0] out_col;
  logic [N-1:0]      tap_ready;
  logic              win_valid;

  line_buffer_taps #(.DATA_W(DW), .LINE_LEN(L), .NUM_LINES(N)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .taps(taps), .out_col(out_col),
    .tap_ready(tap_ready), .win_valid(win_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int col;
    int rdy;
    int tv[N];
    bit tchk[N];
  } exp_t;

  exp_t sb[$];
  int   hist[$];
  int   checks = 0;
  int   errors = 0;
  logic rst_q = 1'b1;
  bit   have_last = 0;
  int   last_data, last_col;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and update the reference model.
  task automatic tick(input bit v, input int d, input bit c, input bit r);
    exp_t e;
    int   i;
    @(posedge clk);
    #1;
    in_valid = v; in_data = DW'(d); clr = c; rst = r;
    if (r) hist.delete();
    else begin
      if (c) hist.delete();
      if (v) begin
        i = hist.size();
        e.data = d;
        e.col  = i % L;
        e.rdy  = 0;
        for (int k = 0; k < N; k++) begin
          e.tv[k] = 0;
          e.tchk[k] = 0;
          if (i / L > k) begin
            e.rdy |= (1 << k);
            e.tv[k] = hist[i - (k + 1) * L];
            e.tchk[k] = 1;
          end
`ifdef LINE_BUFFER_ZERO_FILL_EN
          else e.tchk[k] = 1;
`endif
        end
        hist.push_back(d);
        sb.push_back(e);
      end
    end
  endtask

  task automatic stream(input int first, input int cnt, input bit bubbles);
    for (int i = 0; i < cnt; i++) begin
      tick(1, first + i, 0, 0);
      if (bubbles) tick(0, 0, 0, 0);
    end
  endtask

  always @(posedge clk) rst_q <= rst;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_taps", int'(taps), 0);
      chk("rst_out_col", int'(out_col), 0);
      chk("rst_tap_ready", int'(tap_ready), 0);
      chk("rst_win_valid", int'(win_valid), 0);
      have_last = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) chk("sb_unexpected_out", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_data", int'(out_data), e.data);
        chk("out_col", int'(out_col), e.col);
        chk("tap_ready", int'(tap_ready), e.rdy);
        chk("win_valid", int'(win_valid), int'(e.rdy == (1 << N) - 1));
        for (int k = 0; k < N; k++)
          if (e.tchk[k]) chk($sformatf("taps%0d", k), int'(taps[k*DW +: DW]), e.tv[k]);
        have_last = 1;
        last_data = e.data;
        last_col  = e.col;
      end
    end else if (have_last) begin
      chk("hold_out_data", int'(out_data), last_data);
      chk("hold_out_col", int'(out_col), last_col);
      chk("gap_win_valid", int'(win_valid), 0);
    end
  end

  task automatic do_reset();
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    // Fill and window, contiguous.
    stream(0, 12, 0);
    tick(0, 0, 0, 0);
    // Same stream with bubbles.
    do_reset();
    stream(0, 12, 1);
    // Mid-line clear, then a fresh frame.
    do_reset();
    stream(0, 6, 0);
    tick(0, 0, 1, 0);
    stream(100, 8, 0);
    // Clear together with a pixel.
    tick(1, 50, 1, 0);
    tick(1, 51, 0, 0);
    tick(0, 0, 0, 0);
    // Reset during row 2.
    do_reset();
    stream(0, 10, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    stream(200, 2, 0);
    // Saturation and wrap.
    do_reset();
    stream(0, 40, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
